// File: rtl/netsynth_pkg.sv
`default_nettype none
// ============================================================================
// Module  : netsynth_pkg
// Brief   : Shared types, defaults and helpers for the truth-table sweeper.
// Revision: 1.0
// ============================================================================
package netsynth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  localparam int c_def_n_inputs      = 4;
  localparam int c_def_settle_cycles = 2;

  function automatic int rows(input int n);
    return 1 << n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sweep_row_timer.sv
`default_nettype none
// ============================================================================
// Module  : sweep_row_timer
// Brief   : Row index and settle counters; flags the capture edge of each row.
// Revision: 1.0
// ============================================================================
module sweep_row_timer #(
  parameter int N_INPUTS      = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  output logic [N_INPUTS-1:0] idx,
  output logic                capture,
  output logic                row_last
);

  logic [N_INPUTS-1:0] r_idx;
  logic [7:0]          r_scnt;

  assign idx      = r_idx;
  assign capture  = (r_scnt == 8'(SETTLE_CYCLES));
  assign row_last = &r_idx;

  // Counters sit at zero whenever no sweep is running, so a new sweep starts at row 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_scnt <= '0;
    end else if (!run) begin
      r_idx  <= '0;
      r_scnt <= '0;
    end else if (capture) begin
      if (!row_last) begin
        r_idx <= r_idx + 1'b1;
      end
      r_scnt <= '0;
    end else begin
      r_scnt <= r_scnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module  : truth_table_sweeper
// Brief   : Sweeps all input rows of a gate, captures its truth table and
//           compares it with a latched expected table.
// Revision: 1.0
// ============================================================================
module truth_table_sweeper
  import netsynth_pkg::*;
#(
  parameter int N_INPUTS      = c_def_n_inputs,
  parameter int SETTLE_CYCLES = c_def_settle_cycles
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [rows(N_INPUTS)-1:0]     expected,
  input  logic                          dut_out,
  output logic [N_INPUTS-1:0]           inp,
  output logic                          busy,
  output logic                          done,
  output logic [rows(N_INPUTS)-1:0]     table_out,
  output logic                          match,
  output logic [N_INPUTS:0]             mismatch_count
);

  localparam int c_rows = rows(N_INPUTS);

  localparam logic [1:0] c_st_idle  = IDLE;
  localparam logic [1:0] c_st_sweep = SWEEP;
  localparam logic [1:0] c_st_done  = DONE;

  logic [1:0]          r_state;
  logic [c_rows-1:0]   r_exp;
  logic [c_rows-1:0]   r_table;
  logic [N_INPUTS:0]   r_mm;
  logic                r_match;

  logic                w_run;
  logic [N_INPUTS-1:0] w_idx;
  logic                w_capture;
  logic                w_row_last;
  logic                w_miss;
  logic [N_INPUTS:0]   w_mm_next;

  assign w_run = (r_state == c_st_sweep) && !abort;

  sweep_row_timer #(
    .N_INPUTS      (N_INPUTS),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (w_run),
    .idx      (w_idx),
    .capture  (w_capture),
    .row_last (w_row_last)
  );

  assign w_miss    = dut_out ^ r_exp[w_idx];
  assign w_mm_next = r_mm + {{N_INPUTS{1'b0}}, w_miss};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_exp   <= '0;
      r_table <= '0;
      r_mm    <= '0;
      r_match <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start && !abort) begin
            r_exp   <= expected;
            r_table <= '0;
            r_mm    <= '0;
            r_match <= 1'b0;
            r_state <= c_st_sweep;
          end
        end
        c_st_sweep: begin
          if (abort) begin
            r_table <= '0;
            r_mm    <= '0;
            r_match <= 1'b0;
            r_state <= c_st_idle;
          end else if (w_capture) begin
            r_table[w_idx] <= dut_out;
            r_mm           <= w_mm_next;
            if (w_row_last) begin
              // match is judged on the count including the final row.
              r_match <= (w_mm_next == '0);
              r_state <= c_st_done;
            end
          end
        end
        c_st_done: begin
          if (abort) begin
            r_table <= '0;
            r_mm    <= '0;
            r_match <= 1'b0;
          end
          r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign busy           = (r_state == c_st_sweep);
  assign done           = (r_state == c_st_done);
  assign inp            = busy ? w_idx : '0;
  assign table_out      = r_table;
  assign match          = r_match;
  assign mismatch_count = r_mm;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module  : tb_truth_table_sweeper
// Brief   : Directed and randomized checks of truth_table_sweeper.
// Revision: 1.0
// ============================================================================
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [15:0] expected;
  logic [15:0] gate_tt;
  logic        dut_out;
  logic [3:0]  inp;
  logic        busy, done, match;
  logic [15:0] table_out;
  logic [4:0]  mismatch_count;

  logic        start0;
  logic [3:0]  inp0;
  logic        busy0, done0, match0;
  logic [15:0] table0;
  logic [4:0]  mm0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign dut_out = gate_tt[inp];

  truth_table_sweeper u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
    .dut_out(dut_out), .inp(inp), .busy(busy), .done(done),
    .table_out(table_out), .match(match), .mismatch_count(mismatch_count)
  );

  truth_table_sweeper #(.N_INPUTS(4), .SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(1'b0), .expected(16'h0000),
    .dut_out(1'b1), .inp(inp0), .busy(busy0), .done(done0),
    .table_out(table0), .match(match0), .mismatch_count(mm0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: number of rows where the gate disagrees with the table.
  function automatic int diff_rows(input logic [15:0] a, input logic [15:0] b);
    int c = 0;
    for (int r = 0; r < 16; r++) if (a[r] != b[r]) c++;
    return c;
  endfunction

  task automatic run_sweep(input string tag, input logic [15:0] e, input logic [15:0] g,
                           input bit hold, input bit toggle);
    int cyc = 0;
    int dones = 0;
    int nd;
    expected = e;
    gate_tt  = g;
    start    = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    while (busy === 1'b1 && cyc < 1000) begin
      if (cyc % 8 == 0) chk({tag, "_inp"}, 32'(inp), 32'(cyc / 3));
      if (cyc == 0) chk({tag, "_match_busy"}, 32'(match), 32'd0);
      if (done) dones++;
      if (toggle && cyc == 20) expected = ~expected;
      cyc++;
      tick();
    end
    nd = diff_rows(g, e);
    chk({tag, "_busy_cycles"}, 32'(cyc), 32'd48);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_done_early"}, 32'(dones), 32'd0);
    chk({tag, "_table"}, 32'(table_out), 32'(g));
    chk({tag, "_count"}, 32'(mismatch_count), 32'(nd));
    chk({tag, "_match"}, 32'(match), 32'(nd == 0));
    start = 1'b0;
    tick();
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_table_hold"}, 32'(table_out), 32'(g));
    chk({tag, "_match_hold"}, 32'(match), 32'(nd == 0));
  endtask

  initial begin
    int cyc;
    int dones;
    logic [15:0] g, e;
    rst = 1'b0; start = 1'b0; start0 = 1'b0; abort = 1'b0;
    expected = 16'h0; gate_tt = 16'h0;
    #2 rst = 1'b1;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_inp", 32'(inp), 32'd0);
    chk("rst_table", 32'(table_out), 32'd0);
    chk("rst_count", 32'(mismatch_count), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    rst = 1'b0;
    tick();

    // Gate with ones at rows 9,10,13,14.
    run_sweep("t1", 16'h6600, 16'h6600, 1'b0, 1'b0);
    run_sweep("t2", 16'h6601, 16'h6600, 1'b0, 1'b0);

    // Zero-settle instance, gate tied high.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 0;
    while (busy0 === 1'b1 && cyc < 1000) begin
      chk("t3_inp", 32'(inp0), 32'(cyc));
      cyc++;
      tick();
    end
    chk("t3_busy_cycles", 32'(cyc), 32'd16);
    chk("t3_done", 32'(done0), 32'd1);
    chk("t3_table", 32'(table0), 32'hFFFF);
    chk("t3_count", 32'(mm0), 32'd16);
    chk("t3_match", 32'(match0), 32'd0);

    // Abort 20 cycles into a sweep.
    expected = 16'h1234;
    gate_tt  = 16'h5A5A;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    chk("t4_busy_pre", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_inp", 32'(inp), 32'd0);
    chk("t4_table", 32'(table_out), 32'd0);
    chk("t4_match", 32'(match), 32'd0);
    chk("t4_count", 32'(mismatch_count), 32'd0);
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) dones++;
      tick();
    end
    chk("t4_no_done", 32'(dones), 32'd0);
    run_sweep("t4_restart", 16'h1234, 16'h5A5A, 1'b0, 1'b0);

    // Start held high with expected toggled mid-sweep.
    run_sweep("t5", 16'hC3A5, 16'hC3A4, 1'b1, 1'b1);
    tick();
    chk("t5_single", 32'(busy), 32'd0);

    // Randomized gates and expected tables.
    for (int k = 0; k < 4; k++) begin
      g = 16'($urandom);
      e = (k == 0) ? g : (g ^ 16'($urandom) & 16'($urandom));
      run_sweep("rnd", e, g, 1'b0, 1'b0);
    end

    // Asynchronous reset between edges mid-sweep.
    expected = 16'hFFFF;
    gate_tt  = 16'h0F0F;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_inp", 32'(inp), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_table", 32'(table_out), 32'd0);
    chk("t6_count", 32'(mismatch_count), 32'd0);
    chk("t6_match", 32'(match), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_idle", 32'(busy), 32'd0);
    run_sweep("t6_after", 16'h0F0F, 16'h0F0F, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
